// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing (hsync/vsync/video_on/x/y/frame_start) from an edge-detected pixel_clock; VGA_SYNC_FRAME_CNT_EN adds frame_cnt.
// Latency: outputs load on the CLK edge that samples the pixel_clock rise (pix_en).
// Backpressure: none; free-running, everything holds while pixel_clock stops toggling.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       pixel_clock,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_timing
            $error("vga_sync_gen: line/frame totals must be in 1..1024");
        end
    endgenerate

    // 11-bit thresholds so a boundary equal to 1024 still compares correctly
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

    logic        pix_d;
    logic        pix_en;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [10:0] h_ext;
    logic [10:0] v_ext;
    logic        vis_dec;
    logic        hs_dec;
    logic        vs_dec;
    logic        origin;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pix_d <= 1'b0;
        end else begin
            pix_d <= pixel_clock;
        end
    end

    assign pix_en = pixel_clock & ~pix_d;

    assign h_ext   = {1'b0, h_cnt};
    assign v_ext   = {1'b0, v_cnt};
    assign vis_dec = (h_ext < H_VIS) && (v_ext < V_VIS);
    assign hs_dec  = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    assign vs_dec  = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
    assign origin  = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= 10'd0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Outputs present the position the counters held before this advance
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            video_on    <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                hsync       <= hs_dec ? HS_POL : ~HS_POL;
                vsync       <= vs_dec ? VS_POL : ~VS_POL;
                video_on    <= vis_dec;
                x           <= h_cnt;
                y           <= v_cnt;
                frame_start <= origin;
            end
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    // The first frame after reset reads 0; later frames count up
    logic first_seen;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_cnt  <= 8'd0;
            first_seen <= 1'b0;
        end else if (pix_en && origin) begin
            if (first_seen) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            first_seen <= 1'b1;
        end
    end
`endif

endmodule
